// File: rtl/ext_bus_pkg.sv
// Shared types and constants for the multiplexed external-bus controller.
package ext_bus_pkg;

    typedef enum logic [2:0] {IDLE, ADDR, LATCH, STROBE, RECOVER} state_e;
    typedef enum logic [1:0] {READ, WRITE, CODE} xfer_e;

    localparam int STROBE_PHASES = 2;
    // Wide enough for STROBE_PHASES plus the saturating wait-extension count.
    localparam int PH_W = 2;

endpackage

// File: rtl/ext_bus_ctrl_phase_timer.sv
// Phase timer: counts PHASE_CLKS clocks per phase and flags the end of the
// last requested phase; clr restarts both counters at a state change.
module phase_timer
    import ext_bus_pkg::*;
#(
    parameter int PHASE_CLKS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic [PH_W-1:0] phases,
    output logic            phase_end
);

    localparam int CW = (PHASE_CLKS > 1) ? $clog2(PHASE_CLKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CLKS - 1);

    logic [CW-1:0]   cnt;
    logic [PH_W-1:0] ph;
    logic            last;

    assign last = (cnt == CNT_LAST);
    // ">=" lets an extended STROBE end again at every further phase boundary.
    assign phase_end = last && (ph >= phases - PH_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ph  <= '0;
        end else if (clr) begin
            cnt <= '0;
            ph  <= '0;
        end else if (last) begin
            cnt <= '0;
            if (ph != '1)
                ph <= ph + PH_W'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ext_bus_ctrl.sv
// Multiplexed external-memory bus controller (ALE / PSEN_n / RD_n / WR_n).
// Optional EXT_BUS_WAIT_EN adds a wait_n input that stretches STROBE by phases.
module ext_bus_ctrl
    import ext_bus_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int PHASE_CLKS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef EXT_BUS_WAIT_EN
    input  logic                     wait_n,
`endif
    input  logic                     req,
    input  logic                     req_we,
    input  logic                     req_code,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     req_ack,
    output logic                     busy,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rdata_vld,
    output logic [DATA_W-1:0]        ad_out,
    output logic                     ad_oe,
    input  logic [DATA_W-1:0]        ad_in,
    output logic [ADDR_W-DATA_W-1:0] a_hi,
    output logic                     ale,
    output logic                     psen_n,
    output logic                     rd_n,
    output logic                     wr_n
);

    state_e            state;
    xfer_e             xtype;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [PH_W-1:0]   phases;
    logic              phase_end, stall, advance, clr, accept;

`ifdef EXT_BUS_WAIT_EN
    assign stall = (state == STROBE) && !wait_n;
`else
    assign stall = 1'b0;
`endif
    assign advance = phase_end && !stall;
    assign clr     = (state == IDLE) || advance;
    assign phases  = (state == STROBE) ? PH_W'(STROBE_PHASES) : PH_W'(1);

    // A request is taken on any edge that lands the FSM in IDLE, so a held
    // req gives back-to-back transfers at the minimum 5*P+1 spacing.
    assign accept = req && (((state == IDLE) && !req_ack) ||
                            ((state == RECOVER) && advance));

    phase_timer #(.PHASE_CLKS(PHASE_CLKS)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .phases    (phases),
        .phase_end (phase_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            xtype     <= READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_ack   <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
            rdata_vld <= 1'b0;
            ad_out    <= '0;
            ad_oe     <= 1'b0;
            a_hi      <= '0;
            ale       <= 1'b0;
            psen_n    <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
        end else begin
            req_ack   <= 1'b0;
            rdata_vld <= 1'b0;
            if (accept) begin
                req_ack <= 1'b1;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                xtype   <= req_code ? CODE : (req_we ? WRITE : READ);
            end
            unique case (state)
                IDLE: if (req_ack) begin
                    state  <= ADDR;
                    busy   <= 1'b1;
                    ale    <= 1'b1;
                    ad_out <= addr_q[DATA_W-1:0];
                    ad_oe  <= 1'b1;
                    a_hi   <= addr_q[ADDR_W-1:DATA_W];
                end
                ADDR: if (advance) begin
                    state <= LATCH;
                    ale   <= 1'b0;
                end
                LATCH: if (advance) begin
                    state <= STROBE;
                    unique case (xtype)
                        CODE:  begin psen_n <= 1'b0; ad_oe <= 1'b0; end
                        WRITE: begin wr_n <= 1'b0; ad_out <= wdata_q; ad_oe <= 1'b1; end
                        default: begin rd_n <= 1'b0; ad_oe <= 1'b0; end
                    endcase
                end
                STROBE: if (advance) begin
                    state  <= RECOVER;
                    psen_n <= 1'b1;
                    rd_n   <= 1'b1;
                    wr_n   <= 1'b1;
                    if (xtype != WRITE) begin
                        rdata     <= ad_in;
                        rdata_vld <= 1'b1;
                    end
                end
                RECOVER: if (advance) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ad_oe <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
